// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and base typedefs for the scoreboarded register file.
//   RF_DATA_W   - default register width
//   RF_NUM_REGS - default register count (power of two)
//   RF_NUM_RD   - default number of read ports
//   rf_addr_t / rf_data_t - address and data types at the default sizes
package rf_pkg;

    localparam int RF_DATA_W   = 16;
    localparam int RF_NUM_REGS = 16;
    localparam int RF_NUM_RD   = 2;
    localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of the register file.
// Ports:
//   active     - low while the file is held in reset; forces outputs to zero
//   regs       - full storage array from the top level
//   busy_vec   - registered scoreboard from the top level
//   wr_en/wr_addr/wr_data - same-cycle write, used for bypass and busy clear
//   issue_en/issue_addr   - same-cycle issue, keeps busy set on a write hit
//   rd_en/rd_addr         - this port's enable and address
//   rd_data/rd_busy       - read value and pending-write flag
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                               active,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]    regs,
    input  logic [NUM_REGS-1:0]                busy_vec,
    input  logic                               wr_en,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic                               issue_en,
    input  logic [ADDR_W-1:0]                  issue_addr,
    input  logic                               rd_en,
    input  logic [ADDR_W-1:0]                  rd_addr,
    output logic [DATA_W-1:0]                  rd_data,
    output logic                               rd_busy
);

    logic hit_wr;
    logic hit_iss;
    logic is_zero;

    always_comb begin
        hit_wr  = wr_en && (wr_addr == rd_addr);
        hit_iss = issue_en && (issue_addr == rd_addr);
        is_zero = (ZERO_REG != 0) && (rd_addr == '0);
        rd_data = '0;
        rd_busy = 1'b0;
        if (active && rd_en && !is_zero) begin
            // Write-before-read: a same-cycle write is visible immediately.
            rd_data = hit_wr ? wr_data : regs[rd_addr];
            // A same-cycle write retires the pending bit unless a new
            // producer is issued to the same register in that cycle.
            rd_busy = busy_vec[rd_addr] && !(hit_wr && !hit_iss);
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with write-before-read bypass and a
// per-register pending-write scoreboard.
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - asynchronous active-low reset
//   wr_en/wr_addr/wr_data - write port; a write clears the busy bit
//   rd_en/rd_addr         - per-port read enable and address
//   rd_data/rd_busy       - per-port read value and pending flag
//   issue_en/issue_addr   - marks a destination register pending
//   busy_vec              - registered scoreboard, one bit per register
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic [NUM_RD-1:0]               rd_en,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]               rd_busy,
    input  logic                            issue_en,
    input  logic [ADDR_W-1:0]               issue_addr,
    output logic [NUM_REGS-1:0]             busy_vec
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             busy_nxt;
    logic                            wr_ok;
    logic                            iss_ok;

    // Register 0 silently drops writes and issues when it is hardwired.
    always_comb begin
        wr_ok  = wr_en    && !((ZERO_REG != 0) && (wr_addr == '0));
        iss_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));
    end

    // Clear first, then set, so a same-address issue supersedes the write.
    always_comb begin
        busy_nxt = busy_vec;
        if (wr_ok) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (iss_ok) begin
            busy_nxt[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs     <= '0;
            busy_vec <= '0;
        end else begin
            if (wr_ok) begin
                regs[wr_addr] <= wr_data;
            end
            busy_vec <= busy_nxt;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .active     (rst),
            .regs       (regs),
            .busy_vec   (busy_vec),
            .wr_en      (wr_en),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .issue_en   (issue_en),
            .issue_addr (issue_addr),
            .rd_en      (rd_en[p]),
            .rd_addr    (rd_addr[p]),
            .rd_data    (rd_data[p]),
            .rd_busy    (rd_busy[p])
        );
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed scoreboard bench for reg_file_sb (default sizes).
module tb_reg_file_sb;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int NP = 2;
    localparam int AW = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [DW-1:0]          wr_data;
    logic [NP-1:0]          rd_en;
    logic [NP-1:0][AW-1:0]  rd_addr;
    logic [NP-1:0][DW-1:0]  rd_data;
    logic [NP-1:0]          rd_busy;
    logic                   issue_en;
    logic [AW-1:0]          issue_addr;
    logic [NR-1:0]          busy_vec;

    reg_file_sb #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .NUM_RD   (NP),
        .ZERO_REG (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .busy_vec   (busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        b0;
        logic        b1;
        logic [15:0] bv;
    } exp_t;

    exp_t sb_q[$];
    event chk_ev;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cmp(input string tag, input string what,
                       input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%04h expected 0x%04h", tag, what, act, req);
        end
    endtask

    // Monitor: pops expectations whenever the driver presents a settled cycle.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp(e.tag, "rd_data0", rd_data[0], e.d0);
                cmp(e.tag, "rd_data1", rd_data[1], e.d1);
                cmp(e.tag, "rd_busy0", {15'd0, rd_busy[0]}, {15'd0, e.b0});
                cmp(e.tag, "rd_busy1", {15'd0, rd_busy[1]}, {15'd0, e.b1});
                cmp(e.tag, "busy_vec", busy_vec, e.bv);
            end
        end
    end

    task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic ie, input logic [3:0] ia,
                         input logic [1:0] re, input logic [3:0] ra0, input logic [3:0] ra1);
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        issue_en   = ie;
        issue_addr = ia;
        rd_en      = re;
        rd_addr[0] = ra0;
        rd_addr[1] = ra1;
    endtask

    task automatic post(input string tag, input logic [15:0] d0, input logic [15:0] d1,
                        input logic b0, input logic b1, input logic [15:0] bv);
        sb_q.push_back('{tag, d0, d1, b0, b1, bv});
        -> chk_ev;
    endtask

    // Inputs are applied at the falling edge and checked 1 time unit later.
    task automatic chk(input string tag, input logic [15:0] d0, input logic [15:0] d1,
                       input logic b0, input logic b1, input logic [15:0] bv);
        #1;
        post(tag, d0, d1, b0, b1, bv);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 0, 16'h0, 0, 0, 2'b00, 0, 0);
        #2;
        // Write, issue and bypass attempt while held in reset: all outputs zero.
        drive(1, 2, 16'hDEAD, 1, 2, 2'b11, 2, 0);
        #1 post("rst_hold", 16'h0, 16'h0, 0, 0, 16'h0);
        @(posedge clk);
        #1 post("rst_edge", 16'h0, 16'h0, 0, 0, 16'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int a = 0; a < NR; a++) begin
            drive(0, 0, 16'h0, 0, 0, 2'b11, 4'(a), 4'(NR - 1 - a));
            chk("init_rd", 16'h0, 16'h0, 0, 0, 16'h0);
        end

        drive(1, 5, 16'hBEEF, 0, 0, 2'b11, 5, 6);
        chk("wr5_bypass", 16'hBEEF, 16'h0, 0, 0, 16'h0);
        drive(0, 0, 16'h0, 0, 0, 2'b11, 5, 5);
        chk("rd5", 16'hBEEF, 16'hBEEF, 0, 0, 16'h0);

        drive(0, 0, 16'h0, 1, 3, 2'b00, 0, 0);
        chk("iss3", 16'h0, 16'h0, 0, 0, 16'h0);
        drive(0, 0, 16'h0, 0, 0, 2'b11, 3, 3);
        chk("busy3", 16'h0, 16'h0, 1, 1, 16'h0008);
        drive(1, 3, 16'h1234, 0, 0, 2'b11, 3, 3);
        chk("wr3_clear", 16'h1234, 16'h1234, 0, 0, 16'h0008);
        drive(0, 0, 16'h0, 0, 0, 2'b11, 3, 3);
        chk("rd3", 16'h1234, 16'h1234, 0, 0, 16'h0000);

        drive(1, 7, 16'h00AA, 1, 7, 2'b01, 7, 7);
        chk("iss_wr7", 16'h00AA, 16'h0, 0, 0, 16'h0);
        drive(0, 0, 16'h0, 0, 0, 2'b11, 7, 7);
        chk("rd7_busy", 16'h00AA, 16'h00AA, 1, 1, 16'h0080);

        drive(1, 7, 16'h7777, 1, 4, 2'b11, 7, 4);
        chk("iss4_wr7", 16'h7777, 16'h0, 0, 0, 16'h0080);
        drive(0, 0, 16'h0, 1, 4, 2'b11, 7, 4);
        chk("reiss4", 16'h7777, 16'h0, 0, 1, 16'h0010);
        drive(1, 8, 16'h0808, 0, 0, 2'b11, 4, 8);
        chk("wr8_idle", 16'h0, 16'h0808, 1, 0, 16'h0010);
        drive(0, 0, 16'h0, 0, 0, 2'b11, 8, 4);
        chk("rd8", 16'h0808, 16'h0, 0, 1, 16'h0010);

        drive(1, 0, 16'hFFFF, 1, 0, 2'b11, 0, 0);
        chk("r0_bypass", 16'h0, 16'h0, 0, 0, 16'h0010);
        drive(0, 0, 16'h0, 0, 0, 2'b10, 5, 0);
        chk("r0_after", 16'h0, 16'h0, 0, 0, 16'h0010);

        drive(1, 2, 16'h5555, 0, 0, 2'b00, 0, 0);
        chk("wr2", 16'h0, 16'h0, 0, 0, 16'h0010);
        drive(0, 0, 16'h0, 0, 0, 2'b11, 2, 4);
        chk("rd2", 16'h5555, 16'h0, 0, 1, 16'h0010);

        // Reset pulse between edges with a write and issue in flight.
        drive(1, 2, 16'hDEAD, 1, 6, 2'b11, 2, 4);
        #1 rst = 1'b0;
        #1 post("rst_pulse", 16'h0, 16'h0, 0, 0, 16'h0);
        #1;
        rst = 1'b1;
        drive(1, 2, 16'h1111, 0, 0, 2'b00, 0, 0);
        @(negedge clk);
        drive(0, 0, 16'h0, 0, 0, 2'b11, 2, 5);
        chk("post_rst_wr", 16'h1111, 16'h0, 0, 0, 16'h0);

        #2;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
